// File: rtl/bomber_video_pkg.sv
// Shared sprite-ROM definitions for the video pipeline. The box, bomb and player
// ROM arbiters all use these address and colour widths.
package bomber_video_pkg;

  localparam int SPRITE_ADDR_W = 5;
  localparam int COLOR_W       = 12;
  localparam int STARVE_W      = 8;

  typedef logic [COLOR_W-1:0]       color_t;
  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after start_i, with wrap.
// It has no latency and no backpressure. Index 0 can be excluded so that a priority port can be handled outside the picker.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic          skip_zero_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(start_i) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!any_o && req_i[j] && !(skip_zero_i && (j == 0))) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/box_rom_arbiter.sv
// Shares the box sprite ROM between several pixel requesters. A request is granted in the same cycle, and its tagged colour word returns ROM_LAT cycles later.
// Each cycle at most one request is granted. Requesters that are not granted keep req high and wait. Per-requester counters flag starvation.
module box_rom_arbiter
  import bomber_video_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ROM_LAT    = 1,
  parameter bit          RT_PORT    = 1'b1,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*SPRITE_ADDR_W-1:0] req_row,
  input  logic [N_REQ*SPRITE_ADDR_W-1:0] req_col,
  output logic [N_REQ-1:0]               gnt,
  output logic [SPRITE_ADDR_W-1:0]       rom_row,
  output logic [SPRITE_ADDR_W-1:0]       rom_col,
  input  logic [COLOR_W-1:0]             rom_data,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [COLOR_W-1:0]             rsp_data,
  output logic [N_REQ-1:0]               starve
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The round-robin ring never includes the real-time port, so both reset and wrap return to 1.
  localparam logic [IW-1:0]       PTR_RST = RT_PORT ? IW'(1) : '0;
  localparam logic [STARVE_W-1:0] LIM     = STARVE_W'(STARVE_LIM);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW:0]        ptr_inc;
  logic [N_REQ-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               rt_hit;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [ROM_LAT-1:0] tag_vld_q;
  logic [IW-1:0]      tag_idx_q [ROM_LAT];
  logic [STARVE_W-1:0] wait_q [N_REQ];
  logic [STARVE_W-1:0] wait_d [N_REQ];
  logic [N_REQ-1:0]   starve_q, starve_d;

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i      (req),
    .start_i    (rr_ptr_q),
    .skip_zero_i(RT_PORT),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  always_comb begin
    rt_hit  = RT_PORT && req[0];
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!reset) begin
      if (rt_hit) begin
        gnt[0]  = 1'b1;
        gnt_any = 1'b1;
      end else if (pick_any) begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    rom_row = '0;
    rom_col = '0;
    if (gnt_any) begin
      rom_row = req_row[int'(gnt_idx)*SPRITE_ADDR_W +: SPRITE_ADDR_W];
      rom_col = req_col[int'(gnt_idx)*SPRITE_ADDR_W +: SPRITE_ADDR_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ptr_inc  = {1'b0, pick_idx} + (IW+1)'(1);
    if (!rt_hit && pick_any)
      rr_ptr_d = (ptr_inc == (IW+1)'(N_REQ)) ? PTR_RST : ptr_inc[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= PTR_RST;
      tag_vld_q <= '0;
      for (int s = 0; s < int'(ROM_LAT); s++) tag_idx_q[s] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q[0] <= gnt_any;
      tag_idx_q[0] <= gnt_idx;
      for (int s = 1; s < int'(ROM_LAT); s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  // Reset also masks the tag at the output, so a read that is in flight when reset asserts is not reported.
  always_comb begin
    rsp_valid = '0;
    if (!reset && tag_vld_q[ROM_LAT-1]) rsp_valid[tag_idx_q[ROM_LAT-1]] = 1'b1;
  end

  assign rsp_data = rom_data;

  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      wait_d[i] = wait_q[i];
      if (gnt[i] || !req[i])      wait_d[i] = '0;
      else if (wait_q[i] != '1)   wait_d[i] = wait_q[i] + STARVE_W'(1);
      if (wait_d[i] >= LIM)       starve_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      for (int i = 0; i < int'(N_REQ); i++) wait_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int i = 0; i < int'(N_REQ); i++) wait_q[i] <= wait_d[i];
    end
  end

  assign starve = starve_q;

endmodule

// File: tb/tb_box_rom_arbiter.sv
// Bench with two arbiter instances: one with a real-time port and one in plain round-robin mode.
// Directed vectors push expected responses into queues, and a negedge monitor checks every returned word.
module tb_box_rom_arbiter;
  import bomber_video_pkg::*;

  typedef struct {
    int          due;
    logic [3:0]  vld;
    logic [11:0] dat;
  } exp_t;

  localparam logic [19:0] A_ROW = {5'd20, 5'd13, 5'd3, 5'd30};
  localparam logic [19:0] A_COL = {5'd2,  5'd17, 5'd7, 5'd11};
  localparam logic [19:0] B_ROW = {5'd5,  5'd26, 5'd9, 5'd14};
  localparam logic [19:0] B_COL = {5'd31, 5'd0,  5'd22, 5'd6};

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q_rt[$];
  exp_t q_rr[$];

  logic [3:0]  rt_req, rt_gnt, rt_rsp_valid, rt_starve;
  logic [19:0] rt_row, rt_col;
  logic [4:0]  rt_rom_row, rt_rom_col;
  logic [11:0] rt_rom_q, rt_rsp_data;
  logic [3:0]  rr_req, rr_gnt, rr_rsp_valid, rr_starve;
  logic [19:0] rr_row, rr_col;
  logic [4:0]  rr_rom_row, rr_rom_col;
  logic [11:0] rr_rom_q, rr_rsp_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rom_f(input logic [4:0] r, input logic [4:0] c);
    logic [11:0] a;
    a = {2'b00, r, c};
    return (a * 12'd37) ^ 12'hA5C;
  endfunction

  // Behavioural box ROMs: the address is registered, so data appears one cycle later
  always @(posedge clk) begin
    rt_rom_q <= rom_f(rt_rom_row, rt_rom_col);
    rr_rom_q <= rom_f(rr_rom_row, rr_rom_col);
  end

  box_rom_arbiter #(.N_REQ(4), .ROM_LAT(1), .RT_PORT(1'b1), .STARVE_LIM(64)) u_rt (
    .clk(clk), .reset(reset), .req(rt_req), .req_row(rt_row), .req_col(rt_col),
    .gnt(rt_gnt), .rom_row(rt_rom_row), .rom_col(rt_rom_col), .rom_data(rt_rom_q),
    .rsp_valid(rt_rsp_valid), .rsp_data(rt_rsp_data), .starve(rt_starve)
  );

  box_rom_arbiter #(.N_REQ(4), .ROM_LAT(1), .RT_PORT(1'b0), .STARVE_LIM(64)) u_rr (
    .clk(clk), .reset(reset), .req(rr_req), .req_row(rr_row), .req_col(rr_col),
    .gnt(rr_gnt), .rom_row(rr_rom_row), .rom_col(rr_rom_col), .rom_data(rr_rom_q),
    .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data), .starve(rr_starve)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at posedge+1: drives one cycle of requests, checks the grant and address mux, and queues the response
  task automatic step(input int dut, input logic [3:0] r, input logic [19:0] rows,
                      input logic [19:0] cols, input logic [3:0] eg, input bit push);
    int         gi;
    logic [4:0] er, ec;
    exp_t       e;
    if (dut == 0) begin rt_req = r; rt_row = rows; rt_col = cols; end
    else          begin rr_req = r; rr_row = rows; rr_col = cols; end
    #2;
    gi = -1;
    for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
    er = 5'd0;
    ec = 5'd0;
    if (gi >= 0) begin
      er = rows[gi*5 +: 5];
      ec = cols[gi*5 +: 5];
    end
    if (dut == 0) begin
      chk("rt_gnt", 32'(rt_gnt), 32'(eg));
      chk("rt_rom_row", 32'(rt_rom_row), 32'(er));
      chk("rt_rom_col", 32'(rt_rom_col), 32'(ec));
    end else begin
      chk("rr_gnt", 32'(rr_gnt), 32'(eg));
      chk("rr_rom_row", 32'(rr_rom_row), 32'(er));
      chk("rr_rom_col", 32'(rr_rom_col), 32'(ec));
    end
    if (push && gi >= 0) begin
      e.due = cyc + 1;
      e.vld = eg;
      e.dat = rom_f(er, ec);
      if (dut == 0) q_rt.push_back(e);
      else          q_rr.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle, each instance's rsp_valid must equal the queued expectation or be zero
  initial begin : monitor
    exp_t        e;
    logic [3:0]  ev;
    logic [11:0] ed;
    forever begin
      @(negedge clk);
      ev = 4'b0; ed = 12'h0;
      if (q_rt.size() > 0 && q_rt[0].due == cyc) begin
        e = q_rt.pop_front(); ev = e.vld; ed = e.dat;
      end
      chk("rt_rsp_valid", 32'(rt_rsp_valid), 32'(ev));
      if (ev != 4'b0) chk("rt_rsp_data", 32'(rt_rsp_data), 32'(ed));
      ev = 4'b0; ed = 12'h0;
      if (q_rr.size() > 0 && q_rr[0].due == cyc) begin
        e = q_rr.pop_front(); ev = e.vld; ed = e.dat;
      end
      chk("rr_rsp_valid", 32'(rr_rsp_valid), 32'(ev));
      if (ev != 4'b0) chk("rr_rsp_data", 32'(rr_rsp_data), 32'(ed));
    end
  end

  initial begin : stim
    reset = 1'b1;
    rt_req = '0; rt_row = '0; rt_col = '0;
    rr_req = '0; rr_row = '0; rr_col = '0;
    repeat (3) @(posedge clk);
    #1;
    step(0, 4'b1111, A_ROW, A_COL, 4'b0000, 1'b0);
    reset = 1'b0;
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b0);
    chk("rt_starve_rst", 32'(rt_starve), 32'h0);
    chk("rr_starve_rst", 32'(rr_starve), 32'h0);

    // Real-time port: requester 0 wins while it holds req, and the pointer stays at 1
    for (int k = 0; k < 6; k++) step(0, 4'b1111, A_ROW, A_COL, 4'b0001, 1'b1);
    step(0, 4'b1110, A_ROW, A_COL, 4'b0010, 1'b1);
    step(0, 4'b1110, A_ROW, A_COL, 4'b0100, 1'b1);
    step(0, 4'b1110, A_ROW, A_COL, 4'b1000, 1'b1);
    step(0, 4'b1110, A_ROW, A_COL, 4'b0010, 1'b1);
    // Pointer at 2 with only requester 1 active: the scan wraps past 0 and grants 1 with no idle cycle
    step(0, 4'b0010, A_ROW, A_COL, 4'b0010, 1'b1);
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b1);

    // Starvation: requester 2 waits behind the real-time port
    for (int k = 0; k < 63; k++) step(0, 4'b0101, A_ROW, A_COL, 4'b0001, 1'b1);
    chk("rt_starve_63", 32'(rt_starve), 32'h0);
    step(0, 4'b0101, A_ROW, A_COL, 4'b0001, 1'b1);
    chk("rt_starve_64", 32'(rt_starve), 32'h4);
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b1);
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b1);
    chk("rt_starve_sticky", 32'(rt_starve), 32'h4);

    // Plain round-robin instance
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b1010, B_ROW, B_COL, 4'b0010, 1'b1);
      step(1, 4'b1010, B_ROW, B_COL, 4'b1000, 1'b1);
    end
    step(1, 4'b1111, B_ROW, B_COL, 4'b0001, 1'b1);
    step(1, 4'b1111, B_ROW, B_COL, 4'b0010, 1'b1);
    step(1, 4'b1111, B_ROW, B_COL, 4'b0100, 1'b1);
    step(1, 4'b1111, B_ROW, B_COL, 4'b1000, 1'b1);
    step(1, 4'b1111, B_ROW, B_COL, 4'b0001, 1'b1);
    step(1, 4'b1001, B_ROW, B_COL, 4'b1000, 1'b1);
    step(1, 4'b1001, B_ROW, B_COL, 4'b0001, 1'b1);
    step(1, 4'b0000, B_ROW, B_COL, 4'b0000, 1'b1);
    chk("rr_starve_none", 32'(rr_starve), 32'h0);

    // Reset mid-read: the grant to requester 3 must never produce a response
    step(0, 4'b1000, A_ROW, A_COL, 4'b1000, 1'b0);
    reset = 1'b1;
    step(0, 4'b1000, A_ROW, A_COL, 4'b0000, 1'b0);
    step(0, 4'b1000, A_ROW, A_COL, 4'b0000, 1'b0);
    reset = 1'b0;
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b0);
    chk("rt_starve_cleared", 32'(rt_starve), 32'h0);

    // After reset the pointers are back at 1 (RT instance) and 0 (round-robin instance)
    step(0, 4'b0100, A_ROW, A_COL, 4'b0100, 1'b1);
    step(0, 4'b0000, A_ROW, A_COL, 4'b0000, 1'b1);
    step(1, 4'b0110, B_ROW, B_COL, 4'b0010, 1'b1);
    step(1, 4'b0000, B_ROW, B_COL, 4'b0000, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rt_queue_drained", 32'(q_rt.size()), 32'h0);
    chk("rr_queue_drained", 32'(q_rr.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
